mdu_exe: RTL and testbench
==========================

# mdu_exe

Execute-stage multiply/divide unit of the pipelined MIPS core. Computes MULT/MULTU in one cycle, DIV/DIVU iteratively with a radix-2 restoring divider, and merges MTHI/MTLO into the current HI/LO value. Drives the 64-bit write data and write enable that are carried into the MEM-stage HI/LO register. Requests a pipeline stall while a division is in progress.

## Interface
- DIV_CYCLES, 32: restoring iterations, one quotient bit per cycle.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  EXE-stage flush (exception or branch kill); cancels any operation.
- stage_ready  in  1  EXE may advance this cycle (no stall from other stages).
- md_op  in  3  decoded operation: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
- src_a  in  32  rs operand, already forwarded.
- src_b  in  32  rt operand, already forwarded.
- hilo_cur  in  64  current architectural HI/LO, forwarded; {HI,LO}.
- hilo_o  out  64  result {HI,LO} for the MEM-stage HI/LO register.
- hilo_we  out  1  write enable accompanying hilo_o.
- stall_o  out  1  hold IF/ID/EXE; division not finished.

## Operation
- MULT: hilo_o = signed 32x32 product, 64 bits. MULTU: unsigned product. hilo_we=1 in the same cycle; no stall.
- MTHI: hilo_o = {src_a, hilo_cur[31:0]}. MTLO: hilo_o = {hilo_cur[63:32], src_a}. hilo_we=1; no stall.
- NONE: hilo_we=0, hilo_o=0.
- DIV/DIVU: HI = remainder, LO = quotient.
  - Signed: divide magnitudes. Quotient negated if src_a[31]^src_b[31]; remainder takes sign of src_a. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (32-bit wrap).
  - Divide by zero (src_b==0, either signedness): HI=src_a, LO=0xFFFFFFFF.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with md_op DIV/DIVU and no flush: capture |a|, |b|, sign bits, and the zero flag. Go to BUSY with count=0. stall_o=1.
  - BUSY: one restoring step per cycle. After step DIV_CYCLES-1, go to DONE. stall_o=1, hilo_we=0.
  - DONE: apply sign fixup from registered result; hilo_o valid, hilo_we=1, stall_o=0. If stage_ready, go to IDLE; otherwise hold DONE and keep outputs stable.
- Operands are captured at start, so src_a/src_b changes during BUSY are ignored.
- flush in any state: next state IDLE. hilo_we=0 and stall_o=0 in the same cycle (combinational gating).
- hilo_we is always gated by ~flush.

## Timing
- Reset: state IDLE, count=0, internal registers 0. Outputs: hilo_we=0, stall_o=0, hilo_o=0.
- MULT/MULTU/MTHI/MTLO: 0-cycle latency, combinational from inputs.
- DIV issued in cycle 0 (IDLE):
  - stall_o=1 in cycles 0..32 (33 cycles).
  - DONE in cycle 33: hilo_we=1. The instruction leaves EXE at the end of cycle 33 if stage_ready.
- DONE with stage_ready=0 held N cycles: hilo_we stays 1 and the result is unchanged. Exactly one write reaches MEM, because the pipeline register captures on advance only.
- A DIV arriving directly after DONE→IDLE starts a new division the following cycle; no bubble is required.
- rst mid-division: IDLE next cycle; no write is emitted.

## Structure
- Shared package (defines.vh): md_op encodings, DIV_CYCLES, FSM state encodings.
- Sub-module div_radix2 holds the iteration core: inputs start, cancel, dividend/divisor magnitudes; outputs quotient, remainder, done. It contains the count and the 64-bit partial-remainder shift register.
- mdu_exe holds the FSM, the sign/zero handling, the multiplier, and the MTHI/MTLO merge.
- The multiplier is a single `*` on 33-bit sign-extended operands; it is not pipelined.

## Test plan
- MULT src_a=0xFFFFFFFE (-2), src_b=3 -> same cycle hilo_o=0xFFFFFFFF_FFFFFFFA, hilo_we=1, stall_o=0. MULTU with the same operands -> 0x00000002_FFFFFFFA.
- DIVU 100/7 -> stall_o high 33 cycles, then HI=2, LO=14, hilo_we=1 for one cycle with stage_ready=1.
- DIV -7/2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD. DIV 0x80000000/0xFFFFFFFF -> HI=0, LO=0x80000000.
- DIV 5/0 -> HI=5, LO=0xFFFFFFFF.
- Flush asserted at BUSY cycle 10 -> stall_o=0 and hilo_we=0 that cycle, IDLE next cycle. A following DIVU 9/3 completes normally with HI=0, LO=3.
- DONE with stage_ready low for 3 cycles -> hilo_o stable, hilo_we=1, stall_o=0 throughout; IDLE after stage_ready rises. Then MTLO src_a=0x1234, hilo_cur=0xAAAA0000_BBBB0000 -> hilo_o=0xAAAA0000_00001234.

Source files
------------

// File: rtl/mdu_exe_pkg.sv
// -----------------------------------------------------------------------------
// mdu_exe_pkg
// Shared definitions for the execute-stage multiply/divide unit:
//   - md_op encodings as decoded in ID
//   - divider iteration count and counter width
//   - FSM state encodings
//   - magnitude helper used when capturing signed division operands
// -----------------------------------------------------------------------------
package mdu_exe_pkg;

  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = $clog2(DIV_CYCLES);

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  // Two's-complement negate when neg is set; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    logic [31:0] r;
    if (neg) begin
      r = 32'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/mdu_exe_div_radix2.sv
// -----------------------------------------------------------------------------
// mdu_exe_div_radix2
// Radix-2 restoring divider core on unsigned 32-bit magnitudes, one quotient
// bit per cycle over DIV_CYCLES cycles.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               load dividend/divisor and begin iterating
//   cancel              abort any iteration in progress
//   dividend, divisor   unsigned magnitudes, sampled on start
//   quotient, remainder results; stable from the cycle after done until start
//   done                high during the cycle that performs the last step
// -----------------------------------------------------------------------------
module mdu_exe_div_radix2
  import mdu_exe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cancel,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  // {partial remainder, dividend/quotient} shift register
  logic [63:0]      rem_r;
  logic [31:0]      dvs_r;
  logic [CNT_W-1:0] count_r;
  logic             busy_r;

  logic             fits_s;
  logic [31:0]      diff_s;
  logic [63:0]      rem_next_s;
  logic             last_s;

  // One restoring step. The shifted partial remainder can be 33 bits wide
  // (up to 2*divisor-1), so the trial compare uses rem_r[63:31]; when it fits,
  // the difference is below the divisor and the low 32 bits are exact.
  always_comb begin
    fits_s = {1'b0, rem_r[63:31]} >= {2'b00, dvs_r};
    diff_s = rem_r[62:31] - dvs_r;
    if (fits_s) begin
      rem_next_s = {diff_s, rem_r[30:0], 1'b1};
    end else begin
      rem_next_s = {rem_r[62:0], 1'b0};
    end
  end

  assign last_s    = busy_r && (count_r == CNT_W'(DIV_CYCLES - 1));
  assign done      = last_s;
  assign quotient  = rem_r[31:0];
  assign remainder = rem_r[63:32];

  // Iteration state: load on start, step while busy, hold results afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r   <= 64'd0;
      dvs_r   <= 32'd0;
      count_r <= '0;
      busy_r  <= 1'b0;
    end else if (cancel) begin
      count_r <= '0;
      busy_r  <= 1'b0;
    end else if (start) begin
      rem_r   <= {32'd0, dividend};
      dvs_r   <= divisor;
      count_r <= '0;
      busy_r  <= 1'b1;
    end else if (busy_r) begin
      rem_r   <= rem_next_s;
      count_r <= count_r + CNT_W'(1);
      if (last_s) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= 1'b1;
      end
    end else begin
      busy_r <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_exe.sv
// -----------------------------------------------------------------------------
// mdu_exe
// Execute-stage multiply/divide unit. MULT/MULTU and MTHI/MTLO produce their
// HI/LO write in the issue cycle; DIV/DIVU run on the iterative divider and
// stall the front of the pipeline until the result is ready.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         EXE-stage kill; cancels any operation, gates write and stall
//   stage_ready   EXE may advance this cycle
//   md_op         decoded operation (md_op_e encoding)
//   src_a, src_b  forwarded rs / rt operands
//   hilo_cur      forwarded architectural {HI,LO}
//   hilo_o        {HI,LO} write data for the MEM-stage HI/LO register
//   hilo_we       write enable for hilo_o
//   stall_o       hold IF/ID/EXE while a division is unfinished
// -----------------------------------------------------------------------------
module mdu_exe
  import mdu_exe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stage_ready,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [63:0] hilo_cur,
  output logic [63:0] hilo_o,
  output logic        hilo_we,
  output logic        stall_o
);

  mdu_state_e         state_r;
  logic               neg_q_r;
  logic               neg_rem_r;
  logic               zero_r;

  md_op_e             op_s;
  logic               is_div_s;
  logic               div_signed_s;
  logic               div_start_s;
  logic [31:0]        a_mag_s;
  logic [31:0]        b_mag_s;
  logic [31:0]        quot_s;
  logic [31:0]        rem_s;
  logic               div_done_s;
  logic [31:0]        lo_fix_s;
  logic [31:0]        hi_fix_s;

  logic signed [32:0] mul_a_s;
  logic signed [32:0] mul_b_s;
  logic [63:0]        prod_s;

  assign op_s         = md_op_e'(md_op);
  assign is_div_s     = (op_s == MD_DIV) || (op_s == MD_DIVU);
  assign div_signed_s = (op_s == MD_DIV);
  assign div_start_s  = (state_r == ST_IDLE) && is_div_s && !flush;
  assign a_mag_s      = cond_neg32(src_a, div_signed_s && src_a[31]);
  assign b_mag_s      = cond_neg32(src_b, div_signed_s && src_b[31]);

  mdu_exe_div_radix2 u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_s),
    .cancel    (flush),
    .dividend  (a_mag_s),
    .divisor   (b_mag_s),
    .quotient  (quot_s),
    .remainder (rem_s),
    .done      (div_done_s)
  );

  // Single multiplier; operands are zero- or sign-extended to 33 bits so one
  // signed product serves both MULT and MULTU. Only the low 64 bits are needed.
  assign mul_a_s = {(op_s == MD_MULT) && src_a[31], src_a};
  assign mul_b_s = {(op_s == MD_MULT) && src_b[31], src_b};
  assign prod_s  = 64'(mul_a_s) * 64'(mul_b_s);

  // Sign fixup from the registered divider result. Divide by zero forces
  // LO to all ones; the divider already leaves |src_a| as remainder, and the
  // remainder sign fixup turns that back into src_a.
  always_comb begin
    hi_fix_s = cond_neg32(rem_s, neg_rem_r);
    if (zero_r) begin
      lo_fix_s = 32'hFFFF_FFFF;
    end else begin
      lo_fix_s = cond_neg32(quot_s, neg_q_r);
    end
  end

  // Control FSM and captured sign/zero flags for the division in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      zero_r    <= 1'b0;
    end else if (flush) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (is_div_s) begin
            neg_q_r   <= div_signed_s && (src_a[31] ^ src_b[31]);
            neg_rem_r <= div_signed_s && src_a[31];
            zero_r    <= (src_b == 32'd0);
            state_r   <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (div_done_s) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        ST_DONE: begin
          if (stage_ready) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Output selection; flush overrides write enable and stall in the same cycle.
  always_comb begin
    hilo_o  = 64'd0;
    hilo_we = 1'b0;
    stall_o = 1'b0;
    case (state_r)
      ST_IDLE: begin
        case (op_s)
          MD_MULT, MD_MULTU: begin
            hilo_o  = prod_s;
            hilo_we = 1'b1;
          end
          MD_MTHI: begin
            hilo_o  = {src_a, hilo_cur[31:0]};
            hilo_we = 1'b1;
          end
          MD_MTLO: begin
            hilo_o  = {hilo_cur[63:32], src_a};
            hilo_we = 1'b1;
          end
          MD_DIV, MD_DIVU: begin
            stall_o = 1'b1;
          end
          default: begin
            hilo_we = 1'b0;
          end
        endcase
      end
      ST_BUSY: begin
        stall_o = 1'b1;
      end
      ST_DONE: begin
        hilo_o  = {hi_fix_s, lo_fix_s};
        hilo_we = 1'b1;
      end
      default: begin
        stall_o = 1'b0;
      end
    endcase
    if (flush) begin
      hilo_we = 1'b0;
      stall_o = 1'b0;
    end else begin
      hilo_we = hilo_we;
    end
  end

endmodule

// File: tb/tb_mdu_exe.sv
// -----------------------------------------------------------------------------
// tb_mdu_exe
// Scoreboard bench for mdu_exe: the stimulus thread pushes hand-computed
// {HI,LO} values as it issues operations; a monitor pops and compares each
// time the DUT presents a write that leaves EXE (hilo_we, stage_ready, no
// stall). Stall length, flush gating and DONE-hold behaviour are checked
// directly by the stimulus thread.
// -----------------------------------------------------------------------------
module tb_mdu_exe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        stage_ready;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [63:0] hilo_cur;
  logic [63:0] hilo_o;
  logic        hilo_we;
  logic        stall_o;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [63:0] exp_q[$];
  string       name_q[$];

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  mdu_exe dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .stage_ready (stage_ready),
    .md_op       (md_op),
    .src_a       (src_a),
    .src_b       (src_b),
    .hilo_cur    (hilo_cur),
    .hilo_o      (hilo_o),
    .hilo_we     (hilo_we),
    .stall_o     (stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every write that leaves EXE must match the oldest expectation.
  initial begin
    logic [63:0] e;
    string       nm;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && hilo_we === 1'b1 && stage_ready === 1'b1 && stall_o === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got %h, expected no write", hilo_o);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check(nm, hilo_o, e);
        end
      end
    end
  end

  task automatic issue_single(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [63:0] cur, input logic [63:0] exp, input string nm);
    @(posedge clk);
    #1;
    md_op = op; src_a = a; src_b = b; hilo_cur = cur;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    check({nm, "_stall"}, {63'd0, stall_o}, 64'd0);
    @(posedge clk);
    #1;
    md_op = OP_NONE;
  endtask

  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string nm, input int hold);
    int n;
    @(posedge clk);
    #1;
    md_op = op; src_a = a; src_b = b;
    stage_ready = (hold == 0);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall_o === 1'b1) begin
        n++;
        if (n == 2) begin
          src_a = ~a;
          src_b = 32'h0000_0003;
        end
      end else begin
        break;
      end
    end
    check({nm, "_stall_cycles"}, 64'(n), 64'd33);
    for (int k = 0; k < hold; k++) begin
      if (k > 0) @(negedge clk);
      check({nm, "_hold_we"},    {63'd0, hilo_we}, 64'd1);
      check({nm, "_hold_stall"}, {63'd0, stall_o}, 64'd0);
      check({nm, "_hold_data"},  hilo_o, exp);
    end
    if (hold > 0) begin
      @(posedge clk);
      #1;
      stage_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    md_op = OP_NONE;
    @(negedge clk);
    check({nm, "_single_write"}, {63'd0, hilo_we}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; stage_ready = 1'b1; md_op = OP_NONE;
    src_a = 32'd0; src_b = 32'd0; hilo_cur = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hilo",  hilo_o, 64'd0);
    check("reset_we",    {63'd0, hilo_we}, 64'd0);
    check("reset_stall", {63'd0, stall_o}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    issue_single(OP_MULT,  32'hFFFF_FFFE, 32'd3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFA, "mult_neg2x3");
    issue_single(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 64'd0, 64'h0000_0002_FFFF_FFFA, "multu_fffffffex3");
    issue_single(OP_MTHI,  32'hDEAD_BEEF, 32'd0, 64'h1111_1111_2222_2222,
                 64'hDEAD_BEEF_2222_2222, "mthi");

    @(negedge clk);
    check("none_hilo", hilo_o, 64'd0);
    check("none_we",   {63'd0, hilo_we}, 64'd0);

    run_div(OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, "divu_100_7", 0);
    run_div(OP_DIV,  32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2", 0);
    run_div(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_min_m1", 0);
    run_div(OP_DIV,  32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, "div_5_0", 0);
    run_div(OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 64'h7FFF_FFFE_0000_0001, "divu_big", 0);

    // Flush in the middle of a division.
    @(posedge clk);
    #1;
    md_op = OP_DIVU; src_a = 32'd100; src_b = 32'd3; stage_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall", {63'd0, stall_o}, 64'd0);
    check("flush_we",    {63'd0, hilo_we}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; md_op = OP_NONE;
    @(negedge clk);
    check("flush_idle_stall", {63'd0, stall_o}, 64'd0);
    run_div(OP_DIVU, 32'd9, 32'd3, {32'd0, 32'd3}, "divu_9_3_after_flush", 0);

    // DONE held with stage_ready low, then MTLO.
    run_div(OP_DIV, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, "div_7_m2_hold", 3);
    issue_single(OP_MTLO, 32'h0000_1234, 32'd0, 64'hAAAA_0000_BBBB_0000,
                 64'hAAAA_0000_0000_1234, "mtlo");

    // Reset in the middle of a division: no write may appear.
    @(posedge clk);
    #1;
    md_op = OP_DIV; src_a = 32'd50; src_b = 32'd5;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; md_op = OP_NONE;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_stall", {63'd0, stall_o}, 64'd0);
    check("rst_mid_we",    {63'd0, hilo_we}, 64'd0);
    repeat (40) @(posedge clk);
    run_div(OP_DIVU, 32'd20, 32'd6, {32'd2, 32'd3}, "divu_20_6_after_rst", 0);

    repeat (3) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
